// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encodings, FSM states and default width for the program counter
package pc_pkg;

  localparam int PC_WIDTH = 12;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_SKIP = 2'b10,
    PC_LOAD = 2'b11
  } pc_op_e;

  typedef enum logic {
    RUN = 1'b0,
    IRQ = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - combinational ripple incrementer adding 1 or 2 with carry out
module pc_incr
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             two,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Half-adder chain. The +1 enters at bit 0 and the +2 at bit 1.
  // They are mutually exclusive, so bit 1 only ever sees one of them.
  always_comb begin
    logic c;
    sum = '0;
    c   = ~two;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == 1) begin
        c = c | two;
      end
      sum[i] = a[i] ^ c;
      c      = a[i] & c;
    end
    cout = c;
  end

endmodule

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - 12-bit program counter with hold/inc/skip/load, interrupt vectoring; optional PC_LINK_EN return link
module pc_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             irq,
  output logic             irq_ack,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_n,
`ifdef PC_LINK_EN
  output logic [WIDTH-1:0] link,
`endif
  output logic             wrap
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_n_q;
  logic             wrap_q, wrap_d;
  logic             irq_ack_q, irq_ack_d;
  logic             irq_en_q, irq_en_d;
`ifdef PC_LINK_EN
  logic [WIDTH-1:0] link_q, link_d;
`endif

  logic [WIDTH-1:0] incr_sum;
  logic             incr_cout;

  // The single shared incrementer serves both inc and skip.
  pc_incr #(
    .WIDTH(WIDTH)
  ) u_incr (
    .a    (pc_q),
    .two  (op == PC_SKIP),
    .sum  (incr_sum),
    .cout (incr_cout)
  );

  // Next-state logic: the interrupt wins over op in RUN; step=0 freezes everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrap_d    = wrap_q;
    irq_ack_d = 1'b0;
    irq_en_d  = irq_en_q;
`ifdef PC_LINK_EN
    link_d    = link_q;
`endif
    if (step) begin
      if (state_q == RUN && irq && irq_en_q) begin
        pc_d      = IRQ_VECTOR;
        irq_ack_d = 1'b1;
        irq_en_d  = 1'b0;
        state_d   = IRQ;
`ifdef PC_LINK_EN
        link_d    = pc_q;
`endif
      end else begin
        case (pc_op_e'(op))
          PC_HOLD: pc_d = pc_q;
          PC_INC, PC_SKIP: begin
            pc_d = incr_sum;
            if (incr_cout) begin
              wrap_d = 1'b1;
            end
          end
          PC_LOAD: begin
            pc_d = load_addr;
`ifdef PC_LINK_EN
            // An all-ones target in IRQ means "return to where we came from".
            if (state_q == IRQ && load_addr == '1) begin
              pc_d = link_q;
            end
            link_d = pc_q;
`endif
            if (state_q == IRQ) begin
              state_d  = RUN;
              irq_en_d = 1'b1;
            end
          end
          default: pc_d = pc_q;
        endcase
      end
    end
  end

  // State registers; pc_n is its own flop so the q/nq pair switch on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pc_n_q    <= ~RESET_PC;
      wrap_q    <= 1'b0;
      irq_ack_q <= 1'b0;
      irq_en_q  <= 1'b1;
`ifdef PC_LINK_EN
      link_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_n_q    <= ~pc_d;
      wrap_q    <= wrap_d;
      irq_ack_q <= irq_ack_d;
      irq_en_q  <= irq_en_d;
`ifdef PC_LINK_EN
      link_q    <= link_d;
`endif
    end
  end

  assign pc      = pc_q;
  assign pc_n    = pc_n_q;
  assign wrap    = wrap_q;
  assign irq_ack = irq_ack_q;
`ifdef PC_LINK_EN
  assign link    = link_q;
`endif

endmodule

// File: tb/tb_pc_counter.sv
// tb/tb_pc_counter.sv - randomized and directed self-checking bench for pc_counter
module tb_pc_counter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        step;
  logic [1:0]  op;
  logic [11:0] load_addr;
  logic        irq;
  logic        irq_ack;
  logic [11:0] pc;
  logic [11:0] pc_n;
  logic        wrap;
`ifdef PC_LINK_EN
  logic [11:0] link;
`endif

  int vectors = 0;
  int errors  = 0;

  // Reference model state in plain integers
  int m_pc;
  bit m_wrap;
  bit m_in_irq;
  bit m_ack;
  int m_link;

  pc_counter dut (
    .clk       (clk),
    .rstn      (rstn),
    .step      (step),
    .op        (op),
    .load_addr (load_addr),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .pc        (pc),
    .pc_n      (pc_n),
`ifdef PC_LINK_EN
    .link      (link),
`endif
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = 0; m_wrap = 0; m_in_irq = 0; m_ack = 0; m_link = 0;
  endfunction

  function automatic void model_step(bit st, int o, int a, bit i);
    int t;
    int target;
    m_ack = 0;
    if (!st) return;
    if (!m_in_irq && i) begin
      m_link   = m_pc;
      m_pc     = 1;
      m_ack    = 1;
      m_in_irq = 1;
    end else begin
      case (o)
        1, 2: begin
          t = m_pc + o;
          if (t > 4095) m_wrap = 1;
          m_pc = t % 4096;
        end
        3: begin
          target = a;
`ifdef PC_LINK_EN
          if (m_in_irq && a == 4095) target = m_link;
`endif
          m_link   = m_pc;
          m_pc     = target;
          m_in_irq = 0;
        end
        default: ;
      endcase
    end
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic drive(input bit st, input logic [1:0] o, input logic [11:0] a, input bit i);
    step = st; op = o; load_addr = a; irq = i;
    model_step(st, int'(o), int'(a), i);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; step = 0; op = 2'b00; load_addr = '0; irq = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    drive(1, 2'b01, 12'h000, 0);
    drive(1, 2'b01, 12'h000, 0);
    vectors++;
    if (pc !== 12'h002) begin errors++; $display("FAIL pre_reset_pc got %h want %h", pc, 12'h002); end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (pc !== 12'h000) begin errors++; $display("FAIL async_reset_pc got %h want %h", pc, 12'h000); end
    vectors++;
    if (pc_n !== 12'hFFF) begin errors++; $display("FAIL async_reset_pc_n got %h want %h", pc_n, 12'hFFF); end
    vectors++;
    if (wrap !== 1'b0 || irq_ack !== 1'b0) begin errors++; $display("FAIL reset_flags got wrap=%b ack=%b want 0 0", wrap, irq_ack); end
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    repeat (3) drive(1, 2'b01, 12'h000, 0);
    vectors++;
    if (pc !== 12'h003) begin errors++; $display("FAIL inc_x3 got %h want %h", pc, 12'h003); end
  endtask

  task automatic test_inc_wrap();
    drive(1, 2'b11, 12'hFFE, 0);
    drive(1, 2'b01, 12'h000, 0);
    vectors++;
    if (pc !== 12'hFFF || wrap !== 1'b0) begin errors++; $display("FAIL inc_to_fff got pc=%h wrap=%b want fff 0", pc, wrap); end
    drive(1, 2'b01, 12'h000, 0);
    vectors++;
    if (pc !== 12'h000 || wrap !== 1'b1) begin errors++; $display("FAIL inc_wrap got pc=%h wrap=%b want 000 1", pc, wrap); end
    drive(1, 2'b11, 12'h100, 0);
    vectors++;
    if (pc !== 12'h100 || wrap !== 1'b1) begin errors++; $display("FAIL load_keeps_wrap got pc=%h wrap=%b want 100 1", pc, wrap); end
    vectors++;
    if (pc_n !== 12'hEFF) begin errors++; $display("FAIL pc_n_after_load got %h want %h", pc_n, 12'hEFF); end
  endtask

  task automatic test_skip();
    drive(1, 2'b11, 12'hFFF, 0);
    drive(1, 2'b10, 12'h000, 0);
    vectors++;
    if (pc !== 12'h001 || wrap !== 1'b1) begin errors++; $display("FAIL skip_fff got pc=%h wrap=%b want 001 1", pc, wrap); end
    drive(1, 2'b11, 12'hFFE, 0);
    drive(1, 2'b10, 12'h000, 0);
    vectors++;
    if (pc !== 12'h000) begin errors++; $display("FAIL skip_ffe got %h want %h", pc, 12'h000); end
  endtask

  task automatic test_irq();
    drive(1, 2'b11, 12'h020, 0);
    drive(1, 2'b01, 12'h000, 1);
    vectors++;
    if (pc !== 12'h001 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_entry got pc=%h ack=%b want 001 1", pc, irq_ack); end
    drive(1, 2'b01, 12'h000, 1);
    vectors++;
    if (pc !== 12'h002 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_masked got pc=%h ack=%b want 002 0", pc, irq_ack); end
    drive(1, 2'b11, 12'h021, 1);
    vectors++;
    if (pc !== 12'h021 || irq_ack !== 1'b0) begin errors++; $display("FAIL irq_return got pc=%h ack=%b want 021 0", pc, irq_ack); end
    drive(1, 2'b01, 12'h000, 1);
    vectors++;
    if (pc !== 12'h001 || irq_ack !== 1'b1) begin errors++; $display("FAIL irq_reenabled got pc=%h ack=%b want 001 1", pc, irq_ack); end
    drive(1, 2'b11, 12'h030, 0);
  endtask

  task automatic test_stall();
    drive(1, 2'b11, 12'h055, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 2'b01, 12'h000, 1);
      vectors++;
      if (pc !== 12'h055 || irq_ack !== 1'b0) begin errors++; $display("FAIL stall_%0d got pc=%h ack=%b want 055 0", k, pc, irq_ack); end
    end
    drive(1, 2'b01, 12'h000, 0);
    vectors++;
    if (pc !== 12'h056) begin errors++; $display("FAIL stall_release got %h want %h", pc, 12'h056); end
  endtask

`ifdef PC_LINK_EN
  task automatic test_link();
    drive(1, 2'b11, 12'h040, 0);
    drive(1, 2'b00, 12'h000, 1);
    vectors++;
    if (link !== 12'h040 || pc !== 12'h001) begin errors++; $display("FAIL link_capture got link=%h pc=%h want 040 001", link, pc); end
    drive(1, 2'b11, 12'hFFF, 0);
    vectors++;
    if (pc !== 12'h040) begin errors++; $display("FAIL link_return got %h want %h", pc, 12'h040); end
    drive(1, 2'b00, 12'h000, 1);
    vectors++;
    if (irq_ack !== 1'b1) begin errors++; $display("FAIL link_run_again got ack=%b want 1", irq_ack); end
    drive(1, 2'b11, 12'h010, 0);
  endtask
`endif

  task automatic test_random();
    bit          st;
    logic [1:0]  o;
    logic [11:0] a;
    bit          i;
    for (int n = 0; n < 600; n++) begin
      st = ($urandom_range(0, 3) != 0);
      o  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 12'hFFF;
        1:       a = 12'hFFE;
        default: a = 12'($urandom);
      endcase
      i = ($urandom_range(0, 5) == 0);
      drive(st, o, a, i);
      vectors++;
      if (pc !== 12'(m_pc)) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", n, pc, 12'(m_pc)); end
      vectors++;
      if (pc_n !== ~12'(m_pc)) begin errors++; $display("FAIL rand_pc_n[%0d] got %h want %h", n, pc_n, ~12'(m_pc)); end
      vectors++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL rand_wrap[%0d] got %b want %b", n, wrap, m_wrap); end
      vectors++;
      if (irq_ack !== m_ack) begin errors++; $display("FAIL rand_ack[%0d] got %b want %b", n, irq_ack, m_ack); end
`ifdef PC_LINK_EN
      vectors++;
      if (link !== 12'(m_link)) begin errors++; $display("FAIL rand_link[%0d] got %h want %h", n, link, 12'(m_link)); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_skip();
    test_irq();
    test_stall();
`ifdef PC_LINK_EN
    test_link();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
